tb_eth_pkt_generator: RTL and testbench

- Synthesizable Ethernet stream source that sits directly upstream of the stream monitor; drives the same stream signals (data, valid, ready, sop, eop, mod).
- Generates framed packets with deterministic lengths and a checkable payload pattern, honours backpressure, and inserts a programmable inter-packet gap.
- Used in simulation benches and on-chip loopback tests to feed the MAC/NAP path and the downstream monitor.

---
 rtl/tb_eth_pkt_generator_if.sv | 9 +
 rtl/tb_eth_pkt_generator.sv | 86 ++++++++
 tb/tb_tb_eth_pkt_generator.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/tb_eth_pkt_generator_if.sv
// tb_eth_pkt_generator_if: framed Ethernet stream beat bus (data/valid/ready/sop/eop/mod)
interface tb_eth_pkt_generator_if #(parameter int DATA_WIDTH = 256);
  localparam int MW = $clog2(DATA_WIDTH / 8);
  logic valid, ready, sop, eop;
  logic [DATA_WIDTH-1:0] data;
  logic [MW-1:0] mod;
  modport master(output valid, data, sop, eop, mod, input ready);
  modport slave(input valid, data, sop, eop, mod, output ready);
endinterface

// File: rtl/tb_eth_pkt_generator.sv
// tb_eth_pkt_generator: framed packet source with length sweep, seq/len payload, backpressure and gap
module tb_eth_pkt_generator #(
  parameter int DATA_WIDTH = 256,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int NUM_PKTS = 0,
  parameter int IPG_CYCLES = 0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_start,
  input  logic i_enable,
  tb_eth_pkt_generator_if.master s,
  output logic [31:0] o_pkt_count,
  output logic o_busy,
  output logic o_done
);
  localparam int BW = DATA_WIDTH / 8;
  localparam int MW = $clog2(BW);
  typedef enum logic [1:0] {IDLE, GAP, SEND, DONE} state_t;
  state_t state, state_d;
  logic [15:0] len, beat, nbeats;
  logic [31:0] seq, gap_cnt;
  logic [DATA_WIDTH-1:0] payload;
  logic xfer, last, fin, start_ok, done_hit;
  assign nbeats = 16'((32'(len) + 32'(BW - 1)) >> MW);
  assign last = beat == nbeats - 16'd1;
  assign xfer = s.valid & s.ready;
  assign fin = xfer & last;
  assign start_ok = i_start & (state == IDLE | state == DONE);
  assign done_hit = NUM_PKTS != 0 && o_pkt_count + 32'd1 == 32'(NUM_PKTS);
  assign s.valid = state == SEND;
  assign s.sop = s.valid & (beat == 16'd0);
  assign s.eop = s.valid & last;
  assign s.mod = s.eop ? len[MW-1:0] : '0;
  assign s.data = s.valid ? payload : '0;
  assign o_busy = state == GAP || state == SEND;
  assign o_done = state == DONE;
  for (genvar i = 0; i < BW; i++) begin : g_byte
    logic [31:0] b;
    logic [7:0] sb;
    assign b = {16'd0, beat} * 32'(BW) + 32'(i);
    assign sb = 8'(seq >> {b[1:0], 3'b000});
    assign payload[8*i +: 8] = b >= {16'd0, len} ? 8'd0 : b < 32'd4 ? sb :
                               b < 32'd6 ? (b[0] ? len[15:8] : len[7:0]) : b[7:0];
  end
  // next-state: eop transfer decides DONE / GAP / back-to-back SEND
  always_comb begin
    state_d = state;
    case (state)
      IDLE: state_d = i_start ? SEND : IDLE;
      SEND: if (fin) state_d = done_hit ? DONE : (IPG_CYCLES > 0 || !i_enable) ? GAP : SEND;
      GAP: if (gap_cnt <= 32'd1 && i_enable) state_d = SEND;
      DONE: state_d = i_start ? SEND : DONE;
      default: state_d = IDLE;
    endcase
  end
  // state, beat/length/sequence/packet counters and gap timer
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      len <= 16'(MIN_LEN);
      seq <= '0;
      o_pkt_count <= '0;
      beat <= '0;
      gap_cnt <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE || start_ok) begin
        len <= 16'(MIN_LEN);
        seq <= '0;
        o_pkt_count <= '0;
        beat <= '0;
      end else if (xfer) begin
        beat <= last ? 16'd0 : beat + 16'd1;
        if (last) begin
          o_pkt_count <= o_pkt_count + 32'd1;
          seq <= seq + 32'd1;
          len <= len == 16'(MAX_LEN) ? 16'(MIN_LEN) : len + 16'd1;
        end
      end
      if (fin) gap_cnt <= 32'(IPG_CYCLES);
      else if (state == GAP && gap_cnt != 32'd0) gap_cnt <= gap_cnt - 32'd1;
    end
  end
endmodule

// File: tb/tb_tb_eth_pkt_generator.sv
// tb_tb_eth_pkt_generator: scoreboard bench for the packet generator (31..33 byte sweep, gap 2)
module tb_tb_eth_pkt_generator;
  localparam int DW = 256;
  localparam int BW = DW / 8;
  localparam int MW = $clog2(BW);
  localparam int MINL = 31;
  localparam int MAXL = 33;
  localparam int NP = 5;
  localparam int IPG = 2;
  typedef struct packed {
    logic [DW-1:0] data;
    logic sop, eop;
    logic [MW-1:0] mod;
  } beat_t;
  logic clk = 0, rst = 1, start = 0, en = 1;
  logic [31:0] pkt_count;
  logic busy, done;
  int passed = 0, total = 0;
  beat_t q[$];
  bit chk_gap = 1;
  tb_eth_pkt_generator_if #(.DATA_WIDTH(DW)) s();
  tb_eth_pkt_generator #(.DATA_WIDTH(DW), .MIN_LEN(MINL), .MAX_LEN(MAXL), .NUM_PKTS(NP),
                         .IPG_CYCLES(IPG)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_enable(en), .s(s),
    .o_pkt_count(pkt_count), .o_busy(busy), .o_done(done));
  always #5 clk = ~clk;
  task automatic chk(string n, logic [511:0] a, logic [511:0] e);
    total++;
    if (a !== e) $display("FAIL %s: got %0h expected %0h", n, a, e);
    else passed++;
  endtask
  function automatic void push_pkt(int sq, int ln, int maxb);
    int nb, b;
    beat_t e;
    logic [7:0] v;
    nb = (ln + BW - 1) / BW;
    for (int k = 0; k < nb && k < maxb; k++) begin
      e.data = '0;
      for (int i = 0; i < BW; i++) begin
        b = k * BW + i;
        if (b >= ln) v = 8'd0;
        else if (b < 4) v = 8'(sq >> (8 * b));
        else if (b < 6) v = 8'(ln >> (8 * (b - 4)));
        else v = 8'(b);
        e.data[8*i +: 8] = v;
      end
      e.sop = k == 0;
      e.eop = k == nb - 1;
      e.mod = e.eop ? MW'(ln % BW) : '0;
      q.push_back(e);
    end
  endfunction
  function automatic void push_run(int npk, int lastbeats);
    for (int p = 0; p < npk; p++)
      push_pkt(p, MINL + p % (MAXL - MINL + 1), p == npk - 1 ? lastbeats : 99);
  endfunction
  // monitor: pop/compare on transfers, hold-stability under backpressure, gap length
  logic [DW+MW+1:0] pv;
  bit prev_stall = 0, armed = 0;
  int gcnt = 0;
  always @(negedge clk) begin
    if (rst || done) armed = 0;
    else begin
      if (prev_stall) chk("stable", {s.valid, s.data, s.sop, s.eop, s.mod}, {1'b1, pv});
      if (s.valid && s.sop && armed) begin
        if (chk_gap) chk("gap", gcnt, IPG);
        armed = 0;
      end
      if (!s.valid && armed) gcnt++;
      if (s.valid && s.ready) begin
        if (q.size() == 0) chk("spare_beat", 0, 1);
        else chk("beat", {s.data, s.sop, s.eop, s.mod}, q.pop_front());
        if (s.eop) begin
          armed = 1;
          gcnt = 0;
        end
      end
    end
    prev_stall = !rst && s.valid && !s.ready;
    pv = {s.data, s.sop, s.eop, s.mod};
  end
  task automatic start_run();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    @(negedge clk);
    chk("first_beat", {s.valid, s.sop}, 2'b11);
  endtask
  task automatic run_wait(input bit rnd);
    for (int n = 0; n < 400 && !done; n++) begin
      @(posedge clk); #1;
      s.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = n == 4;
    end
    start = 0;
    chk("done", done, 1);
    chk("count", pkt_count, NP);
    chk("idle_out", {busy, s.valid}, 0);
    chk("q_empty", q.size(), 0);
  endtask
  initial begin
    s.ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out", {s.valid, s.sop, s.eop, s.mod, s.data, pkt_count, busy, done}, 0);
    @(posedge clk); #1 rst = 0;
    push_run(NP, 99);
    start_run();
    run_wait(0);
    push_run(NP, 99);
    start_run();
    run_wait(1);
    s.ready = 1;
    chk_gap = 0;
    push_run(NP, 99);
    start_run();
    for (int n = 0; n < 100 && !(pkt_count == 2 && s.valid && s.sop); n++) @(negedge clk);
    chk("reach_pkt2", {pkt_count, s.valid, s.sop}, {32'd2, 2'b11});
    @(posedge clk); #1 en = 0;
    @(negedge clk);
    begin
      bit ok = 1;
      repeat (8) begin
        @(negedge clk);
        ok &= !s.valid && busy && pkt_count == 3;
      end
      chk("enable_hold", ok, 1);
    end
    @(posedge clk); #1 en = 1;
    run_wait(0);
    chk_gap = 1;
    push_run(3, 1);
    start_run();
    for (int n = 0; n < 100 && !(pkt_count == 2 && s.valid && s.sop); n++) @(negedge clk);
    chk("reach_pkt2b", {pkt_count, s.valid, s.sop}, {32'd2, 2'b11});
    @(posedge clk); #1 s.ready = 0;
    @(posedge clk); #1 rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst", {s.valid, s.data, pkt_count, busy}, 0);
    chk("q_empty_rst", q.size(), 0);
    @(posedge clk); #1 rst = 0; s.ready = 1;
    push_run(NP, 99);
    start_run();
    run_wait(0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
